// File: rtl/lsu_mem_master.sv
// ----------------------------------------------------------------------------
// lsu_mem_master
// Load/store initiator between the processor datapath and a single-ported
// word-wide data memory. One request is accepted at a time over a
// valid/ready handshake. Byte, halfword and word accesses are supported.
// Lanes are little-endian. Sub-word loads are sign- or zero-extended, and
// sub-word stores are done as read-modify-write.
//
// Optional feature macro: LSU_RANGE_CHECK_EN
//   defined   : requests reaching past MEM_BYTES are rejected with resp_err.
//   undefined : no range check; the memory aliases on its low index bits.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 halfword, 10 word, 11 reserved (error)
//   req_signed            sign-extend sub-word loads
//   req_addr              byte address
//   req_wdata             right-justified store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_err              request rejected, no memory effect
//   address               word-aligned memory address
//   Write_Data            word written to memory
//   MemRead / MemWrite    memory read / write enables
//   Read_Data             asynchronous memory read data
// ----------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [31:0]       address,
    output logic [31:0]       Write_Data,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [31:0]       Read_Data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic [31:0]         address_q, address_d;
    logic [31:0]         write_data_q, write_data_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                range_err_s;
    logic                req_err_s;

    // Alignment / reserved-size error for a request.
    function automatic logic align_err(input logic [1:0] size, input logic [1:0] lane);
        logic err;
        case (size)
            2'b00:   err = 1'b0;
            2'b01:   err = lane[0];
            2'b10:   err = (lane != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Shift the selected lanes down to bit 0 and extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   res = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h000000, sh[7:0]};
            2'b01:   res = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the target lanes of the captured word with the store data.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                data = {24'h000000, wdata[7:0]} << {lane, 3'b000};
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {lane, 3'b000};
                data = {16'h0000, wdata[15:0]} << {lane, 3'b000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        return (word & ~mask) | (data & mask);
    endfunction

    // Optional out-of-range detection on the incoming request.
`ifdef LSU_RANGE_CHECK_EN
    always_comb begin
        logic [ADDR_W:0] end_addr;
        logic [ADDR_W:0] nbytes;
        case (req_size)
            2'b00:   nbytes = (ADDR_W+1)'(1);
            2'b01:   nbytes = (ADDR_W+1)'(2);
            default: nbytes = (ADDR_W+1)'(4);
        endcase
        end_addr    = {1'b0, req_addr} + nbytes;
        range_err_s = (end_addr > (ADDR_W+1)'(MEM_BYTES));
    end
`else
    // Range check disabled: the memory aliases out-of-range addresses.
    always_comb begin
        range_err_s = 1'b0;
    end
`endif

    // Combined rejection condition for the incoming request.
    always_comb begin
        req_err_s = align_err(req_size, req_addr[1:0]) | range_err_s;
    end

    // Next-state and next-output computation; every output is registered.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0000_0000;
        resp_err_d   = 1'b0;
        address_d    = 32'h0000_0000;
        write_data_d = 32'h0000_0000;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_err_s) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_write) begin
                        state_d    = S_LOAD;
                        mem_read_d = 1'b1;
                        address_d  = 32'(req_addr) & 32'hFFFF_FFFC;
                    end else if (req_size == 2'b10) begin
                        state_d      = S_WR;
                        mem_write_d  = 1'b1;
                        address_d    = 32'(req_addr) & 32'hFFFF_FFFC;
                        write_data_d = req_wdata;
                    end else begin
                        state_d    = S_RMW_RD;
                        mem_read_d = 1'b1;
                        address_d  = 32'(req_addr) & 32'hFFFF_FFFC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_extend(Read_Data, addr_q[1:0], size_q, signed_q);
            end
            S_RMW_RD: begin
                state_d      = S_WR;
                mem_write_d  = 1'b1;
                address_d    = 32'(addr_q) & 32'hFFFF_FFFC;
                write_data_d = merge_store(Read_Data, wdata_q, addr_q[1:0], size_q);
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    // State, latched request fields and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0000_0000;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
            address_q    <= 32'h0000_0000;
            write_data_q <= 32'h0000_0000;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign address    = address_q;
    assign Write_Data = write_data_q;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator sitting between the processor datapath and the single-ported word data memory. It accepts one load or store request at a time over a valid/ready handshake and drives the memory's address, write-data, read-enable and write-enable pins. It supports byte, halfword and word sizes with little-endian lanes, sign or zero extension on loads, and read-modify-write for sub-word stores. It returns a one-cycle response pulse carrying load data or an alignment/range error.

## Interface
Parameters:
- `ADDR_W`, 32: request/memory address width.
- `MEM_BYTES`, 128: byte size of the attached data memory; used only by the range check.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved (treated as error).
- `req_signed` in 1: sign-extend sub-word loads.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: request rejected, no memory effect.
- `address` out 32: word-aligned memory address (`req_addr` with bits [1:0] forced to 0).
- `Write_Data` out 32: word written to memory.
- `MemRead` out 1: memory read enable.
- `MemWrite` out 1: memory write enable; the memory samples it on the rising edge.
- `Read_Data` in 32: asynchronous memory read data.

## Operation
- The request is accepted when `req_valid && req_ready`. `req_ready` = 1 only in IDLE. The request fields, the lane index `addr[1:0]` and the size are latched at acceptance.
- States:
  - IDLE
  - LOAD: MemRead=1, `Read_Data` captured at the edge
  - RMW_RD: MemRead=1, word captured
  - WR: MemWrite=1
  - RESP: `resp_valid` = 1
- Transitions from IDLE on accept:
  - error → RESP
  - load → LOAD
  - word store → WR
  - byte/half store → RMW_RD
- Further transitions: LOAD → RESP; RMW_RD → WR; WR → RESP; RESP → IDLE.
- Error conditions: halfword with `addr[0]`=1; word with `addr[1:0]`≠0; size 11; optional range check (see Configuration). An erroring request gives MemRead = MemWrite = 0 for its whole lifetime.
- Lane rules:
  - Byte k occupies bits [8k+7:8k], where k = `addr[1:0]`.
  - A halfword occupies lanes k and k+1.
  - Sub-word store `Write_Data` = captured word with the target lanes replaced by the low bits of `req_wdata`. Word store `Write_Data` = `req_wdata`.
  - Load: the selected lanes are shifted to bit 0. The result is sign-extended if `req_signed`, else zero-extended. Word loads ignore `req_signed`.
- Memory pins outside the LOAD, RMW_RD and WR states: address = 0, Write_Data = 0, MemRead = MemWrite = 0.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, all memory pins 0.
- Reset is asynchronous. Asserted mid-operation, it immediately deasserts MemWrite and MemRead. A pending RMW write is abandoned and no response is issued.
- Latency in cycles, measured from the accept edge to the `resp_valid` cycle:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - error: 1
- Throughput: the next request is accepted in the cycle after RESP. This is a minimum 1 idle cycle per request, because `req_ready` = 0 during RESP.
- `resp_rdata` and `resp_err` are valid only while `resp_valid` = 1 and are 0 otherwise.
- Memory outputs are driven from registered state and latched fields only; there is no combinational path from `req_*` to the memory pins.

## Configuration
- `LSU_RANGE_CHECK_EN` defined: a request with `req_addr` + access bytes > `MEM_BYTES` is an error, with no memory access and `resp_err`=1.
- Undefined: no range check. The full address is passed to the memory, which aliases on its low index bits.

## Test plan
- Memory word 2 = 0x80FF7F01. Signed byte load at addr 0x0B → `resp_rdata`=0xFFFFFF80 two cycles after accept. Unsigned byte load at addr 0x0B → 0x00000080.
- Word store 0xDEADBEEF at addr 0x10 → MemWrite high exactly one cycle, `address`=0x10, `resp_valid` after 2 cycles. A subsequent word load at 0x10 returns 0xDEADBEEF.
- Memory word at 0x20 = 0x11223344. Halfword store 0xABCD at addr 0x22 → RMW sequence of 3 cycles, memory word becomes 0xABCD3344, MemWrite high one cycle only.
- Word load at addr 0x06 → `resp_err`=1 one cycle after accept, `resp_rdata`=0, MemRead and MemWrite never asserted. The same result for size 11.
- `rst_n` pulsed low during RMW_RD of a byte store → MemRead drops immediately, no write occurs, memory word unchanged, `req_ready`=1 and `resp_valid`=0 after release.
- With `LSU_RANGE_CHECK_EN` defined, word load at addr 0x80 → `resp_err`=1. Without it, the same request reads word index 0.
